dram_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single simulated-DRAM memory port (req/we/addr/be/data) between NUM_REQ AXI-to-memory front ends. Grants are combinational within the request cycle. A per-requester lock keeps the grant for the whole length of an AXI burst. Read data returns on a shared bus with a per-requester valid, aligned to a fixed memory latency. It sits between the AXI slave adapters and the DRAM model port in the simulation memory subsystem.

---
 rtl/dram_port_arbiter_pkg.sv | 40 ++++
 rtl/dram_port_arbiter_if.sv | 35 +++
 rtl/dram_port_arbiter_rr_arbiter.sv | 26 ++
 rtl/dram_port_arbiter.sv | 110 +++++++++++
 tb/tb_dram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and the round-robin scan used by the DRAM port arbiter.
package dram_arb_pkg;

    // Upper bound on requesters; the response id field is sized for it.
    localparam int MAX_REQ   = 8;
    localparam int RESP_ID_W = 3;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [RESP_ID_W-1:0] id;
    } resp_t;

    // Priority scan of the first n request bits, starting at 'start' and wrapping.
    function automatic void rr_pick(
        input  logic [MAX_REQ-1:0] req,
        input  int                 start,
        input  int                 n,
        output logic               found,
        output int                 idx
    );
        int cand;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                cand = (start + i) % n;
                if (req[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and memory-side signals of the DRAM port arbiter.
interface dram_arb_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]                     req_i;
    logic [NUM_REQ-1:0]                     lock_i;
    logic [NUM_REQ-1:0]                     we_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i;
    logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   be_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i;
    logic [NUM_REQ-1:0]                     gnt_o;
    logic [NUM_REQ-1:0]                     rvalid_o;
    logic [DATA_WIDTH-1:0]                  rdata_o;
    logic                                   req_o;
    logic                                   we_o;
    logic [ADDR_WIDTH-1:0]                  addr_o;
    logic [DATA_WIDTH/8-1:0]                be_o;
    logic [DATA_WIDTH-1:0]                  data_o;
    logic [DATA_WIDTH-1:0]                  data_i;

    // Arbiter view: takes requests and memory read data, drives grants and the port.
    modport slave (
        input  req_i, lock_i, we_i, addr_i, be_i, wdata_i, data_i,
        output gnt_o, rvalid_o, rdata_o, req_o, we_o, addr_o, be_o, data_o
    );

    // Front-end / memory-model view.
    modport master (
        output req_i, lock_i, we_i, addr_i, be_i, wdata_i, data_i,
        input  gnt_o, rvalid_o, rdata_o, req_o, we_o, addr_o, be_o, data_o
    );

endinterface

// File: rtl/dram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: request vector + start index -> one-hot, index, any.
module rr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic found;
    int   idx;

    // Scan from the start index and expand the winner to a one-hot grant.
    always_comb begin
        rr_pick(MAX_REQ'(req_i), int'(start_i), NUM_REQ, found, idx);
        any_o = found;
        idx_o = IDX_W'(idx);
        gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM model port between NUM_REQ front ends,
// with burst locking and a fixed-latency read response pipe.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    dram_arb_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   sel;
    logic [NUM_REQ-1:0] gnt;
    logic               mem_req;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    resp_t              pipe_q [MEM_LATENCY];
    resp_t              last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (bus.req_i),
        .start_i (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Grant selection, priority rotation and lock tracking.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        sel     = '0;
        gnt     = '0;
        case (state_q)
            ARB: begin
                if (arb_any) begin
                    sel  = arb_idx;
                    gnt  = arb_gnt;
                    rr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                    if (bus.lock_i[arb_idx]) begin
                        state_d = LOCKED;
                        owner_d = arb_idx;
                    end
                end
            end
            LOCKED: begin
                sel = owner_q;
                if (bus.req_i[owner_q]) begin
                    gnt = NUM_REQ'(1) << owner_q;
                end
                if (!bus.lock_i[owner_q]) begin
                    state_d = ARB;
                end
            end
        endcase
    end

    assign mem_req      = |gnt;
    assign bus.gnt_o    = gnt;
    assign bus.req_o    = mem_req;
    assign bus.we_o     = mem_req & bus.we_i[sel];
    assign bus.addr_o   = mem_req ? bus.addr_i[sel]  : '0;
    assign bus.be_o     = mem_req ? bus.be_i[sel]    : '0;
    assign bus.data_o   = mem_req ? bus.wdata_i[sel] : '0;

    // Arbitration state; reset releases any lock and restarts priority at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // Read response pipe: each granted read travels MEM_LATENCY stages with its id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: mem_req & ~bus.we_o, id: RESP_ID_W'(sel)};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last         = pipe_q[MEM_LATENCY-1];
    assign bus.rvalid_o = last.valid ? (NUM_REQ'(1) << IDX_W'(last.id)) : '0;
    assign bus.rdata_o  = bus.data_i;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: one instance at latency 1, one at latency 3.
module tb_dram_port_arbiter;

    logic clk_i = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk_i = ~clk_i;

    dram_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus_a ();
    dram_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus_b ();

    dram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(1)) dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_a_n),
        .bus    (bus_a.slave)
    );

    dram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(3)) dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_b_n),
        .bus    (bus_b.slave)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    logic [63:0] mem_a_q;
    logic [63:0] mem_b_q [3];

    // DRAM models: the read word appears MEM_LATENCY cycles after the address.
    always @(posedge clk_i) begin
        mem_a_q    <= mem_word(bus_a.addr_o);
        mem_b_q[0] <= mem_word(bus_b.addr_o);
        mem_b_q[1] <= mem_b_q[0];
        mem_b_q[2] <= mem_b_q[1];
    end
    assign bus_a.data_i = mem_a_q;
    assign bus_b.data_i = mem_b_q[2];

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_a;
        bus_a.req_i = '0; bus_a.lock_i = '0; bus_a.we_i = '0;
        bus_a.addr_i = '0; bus_a.be_i = '0; bus_a.wdata_i = '0;
    endtask

    task automatic idle_b;
        bus_b.req_i = '0; bus_b.lock_i = '0; bus_b.we_i = '0;
        bus_b.addr_i = '0; bus_b.be_i = '0; bus_b.wdata_i = '0;
    endtask

    task automatic reset_a;
        rst_a_n = 1'b0;
        tick;
        rst_a_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_a;
        idle_b;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #3;
        tests_run++;
        if (bus_a.gnt_o !== 2'b00 || bus_b.gnt_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt: got %b/%b want 00/00", bus_a.gnt_o, bus_b.gnt_o);
        end
        tests_run++;
        if (bus_a.rvalid_o !== 2'b00 || bus_b.rvalid_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_rvalid: got %b/%b want 00/00", bus_a.rvalid_o, bus_b.rvalid_o);
        end
        tests_run++;
        if (bus_a.req_o !== 1'b0 || bus_a.we_o !== 1'b0 || bus_a.addr_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_port: got req %b we %b addr %h want 0 0 0",
                     bus_a.req_o, bus_a.we_o, bus_a.addr_o);
        end
        tick;
        tick;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    task automatic test_single_read;
        bus_a.req_i     = 2'b01;
        bus_a.addr_i[0] = 64'h1000;
        #2;
        tests_run++;
        if (bus_a.gnt_o !== 2'b01 || bus_a.req_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_gnt: got gnt %b req %b want 01 1", bus_a.gnt_o, bus_a.req_o);
        end
        tests_run++;
        if (bus_a.addr_o !== 64'h1000 || bus_a.we_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_addr: got %h we %b want 1000 we 0", bus_a.addr_o, bus_a.we_o);
        end
        tick;
        idle_a;
        #2;
        tests_run++;
        if (bus_a.rvalid_o !== 2'b01 || bus_a.rdata_o !== mem_word(64'h1000)) begin
            tests_failed++;
            $display("[TB] FAIL single_rvalid: got %b %h want 01 %h",
                     bus_a.rvalid_o, bus_a.rdata_o, mem_word(64'h1000));
        end
        tests_run++;
        if (bus_a.gnt_o !== 2'b00 || bus_a.addr_o !== 64'h0 || bus_a.be_o !== 8'h0 || bus_a.data_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL idle_zero: got gnt %b addr %h be %h data %h want all zero",
                     bus_a.gnt_o, bus_a.addr_o, bus_a.be_o, bus_a.data_o);
        end
        tick;
    endtask

    task automatic test_contention;
        logic [1:0]  exp_gnt;
        logic [1:0]  prev_gnt;
        logic [63:0] prev_addr;
        reset_a;
        prev_gnt  = 2'b00;
        prev_addr = '0;
        for (int k = 0; k < 5; k++) begin
            bus_a.req_i     = (k < 4) ? 2'b11 : 2'b00;
            bus_a.addr_i[0] = 64'h100 + 64'(k);
            bus_a.addr_i[1] = 64'h200 + 64'(k);
            exp_gnt = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            #2;
            tests_run++;
            if (bus_a.gnt_o !== exp_gnt) begin
                tests_failed++;
                $display("[TB] FAIL contention_gnt[%0d]: got %b want %b", k, bus_a.gnt_o, exp_gnt);
            end
            if (k > 0) begin
                tests_run++;
                if (bus_a.rvalid_o !== prev_gnt || bus_a.rdata_o !== mem_word(prev_addr)) begin
                    tests_failed++;
                    $display("[TB] FAIL contention_rvalid[%0d]: got %b %h want %b %h",
                             k, bus_a.rvalid_o, bus_a.rdata_o, prev_gnt, mem_word(prev_addr));
                end
            end
            prev_gnt  = exp_gnt;
            prev_addr = (exp_gnt == 2'b01) ? 64'h100 + 64'(k) : 64'h200 + 64'(k);
            tick;
        end
        idle_a;
    endtask

    task automatic test_burst_lock;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        for (int k = 0; k < 6; k++) begin
            bus_a.req_i[1]    = (k < 4);
            bus_a.we_i[1]     = 1'b1;
            bus_a.lock_i[1]   = (k < 3);
            bus_a.addr_i[1]   = 64'h300 + 64'(k);
            bus_a.wdata_i[1]  = 64'hAAAA_0000 + 64'(k);
            bus_a.be_i[1]     = 8'hF0;
            bus_a.req_i[0]    = (k >= 1 && k <= 4);
            bus_a.addr_i[0]   = 64'h400;
            exp_gnt = (k < 4) ? 2'b10 : ((k == 4) ? 2'b01 : 2'b00);
            exp_rv  = (k == 5) ? 2'b01 : 2'b00;
            #2;
            tests_run++;
            if (bus_a.gnt_o !== exp_gnt || bus_a.rvalid_o !== exp_rv) begin
                tests_failed++;
                $display("[TB] FAIL burst_gnt[%0d]: got gnt %b rvalid %b want %b %b",
                         k, bus_a.gnt_o, bus_a.rvalid_o, exp_gnt, exp_rv);
            end
            if (k < 4) begin
                tests_run++;
                if (bus_a.we_o !== 1'b1 || bus_a.data_o !== 64'hAAAA_0000 + 64'(k) ||
                    bus_a.be_o !== 8'hF0 || bus_a.addr_o !== 64'h300 + 64'(k)) begin
                    tests_failed++;
                    $display("[TB] FAIL burst_write[%0d]: got we %b addr %h data %h be %h", k,
                             bus_a.we_o, bus_a.addr_o, bus_a.data_o, bus_a.be_o);
                end
            end
            if (k == 5) begin
                tests_run++;
                if (bus_a.rdata_o !== mem_word(64'h400)) begin
                    tests_failed++;
                    $display("[TB] FAIL burst_rdata: got %h want %h", bus_a.rdata_o, mem_word(64'h400));
                end
            end
            tick;
        end
        idle_a;
    endtask

    task automatic test_lock_bubble;
        logic [1:0]  exp_gnt [6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        logic [1:0]  exp_rv  [6] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
        logic [63:0] exp_a   [6] = '{64'h0, 64'h600, 64'h0, 64'h0, 64'h603, 64'h500};
        for (int k = 0; k < 6; k++) begin
            bus_a.req_i[0]  = (k <= 4);
            bus_a.addr_i[0] = 64'h500;
            bus_a.req_i[1]  = (k == 0 || k == 3);
            bus_a.lock_i[1] = (k < 3);
            bus_a.addr_i[1] = 64'h600 + 64'(k);
            #2;
            tests_run++;
            if (bus_a.gnt_o !== exp_gnt[k] || bus_a.rvalid_o !== exp_rv[k]) begin
                tests_failed++;
                $display("[TB] FAIL bubble[%0d]: got gnt %b rvalid %b want %b %b",
                         k, bus_a.gnt_o, bus_a.rvalid_o, exp_gnt[k], exp_rv[k]);
            end
            if (exp_rv[k] != 2'b00) begin
                tests_run++;
                if (bus_a.rdata_o !== mem_word(exp_a[k])) begin
                    tests_failed++;
                    $display("[TB] FAIL bubble_rdata[%0d]: got %h want %h", k, bus_a.rdata_o, mem_word(exp_a[k]));
                end
            end
            tick;
        end
        idle_a;
    endtask

    task automatic test_reset_mid_burst;
        // Requester 0 locks with a read in flight, leaving priority at 1.
        bus_a.req_i     = 2'b01;
        bus_a.lock_i    = 2'b01;
        bus_a.addr_i[0] = 64'h700;
        #2;
        tests_run++;
        if (bus_a.gnt_o !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pre_gnt: got %b want 01", bus_a.gnt_o);
        end
        tick;
        rst_a_n = 1'b0;
        idle_a;
        #2;
        tests_run++;
        if (bus_a.rvalid_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_drop: got rvalid %b want 00", bus_a.rvalid_o);
        end
        tick;
        rst_a_n = 1'b1;
        bus_a.req_i = 2'b11;
        #2;
        tests_run++;
        if (bus_a.gnt_o !== 2'b01 || bus_a.rvalid_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_rr: got gnt %b rvalid %b want 01 00", bus_a.gnt_o, bus_a.rvalid_o);
        end
        tick;
        // Requester 1 locks, reset hits, then only requester 0 asks.
        bus_a.req_i  = 2'b10;
        bus_a.lock_i = 2'b10;
        #2;
        tests_run++;
        if (bus_a.gnt_o !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL midreset_lock1_gnt: got %b want 10", bus_a.gnt_o);
        end
        tick;
        rst_a_n = 1'b0;
        idle_a;
        tick;
        rst_a_n = 1'b1;
        bus_a.req_i = 2'b01;
        #2;
        tests_run++;
        if (bus_a.gnt_o !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL midreset_unlock: got %b want 01", bus_a.gnt_o);
        end
        tick;
        idle_a;
    endtask

    task automatic test_latency3;
        logic [1:0]  g_hist [8];
        logic [63:0] a_hist [8];
        logic [1:0]  exp_rv;
        for (int k = 0; k < 8; k++) begin
            bus_b.req_i     = (k < 4) ? 2'b11 : 2'b00;
            bus_b.addr_i[0] = 64'h800 + 64'(k);
            bus_b.addr_i[1] = 64'h900 + 64'(k);
            g_hist[k] = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            a_hist[k] = (g_hist[k] == 2'b01) ? 64'h800 + 64'(k) : 64'h900 + 64'(k);
            exp_rv    = (k >= 3) ? g_hist[k-3] : 2'b00;
            #2;
            tests_run++;
            if (bus_b.gnt_o !== g_hist[k] || bus_b.rvalid_o !== exp_rv) begin
                tests_failed++;
                $display("[TB] FAIL lat3[%0d]: got gnt %b rvalid %b want %b %b",
                         k, bus_b.gnt_o, bus_b.rvalid_o, g_hist[k], exp_rv);
            end
            if (exp_rv != 2'b00) begin
                tests_run++;
                if (bus_b.rdata_o !== mem_word(a_hist[k-3])) begin
                    tests_failed++;
                    $display("[TB] FAIL lat3_rdata[%0d]: got %h want %h", k, bus_b.rdata_o, mem_word(a_hist[k-3]));
                end
            end
            tick;
        end
        idle_b;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_burst_lock;
        test_lock_bubble;
        test_reset_mid_burst;
        test_latency3;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
